// File: rtl/serial_parity_acc.sv
// serial_parity_acc: bit-serial running-XOR parity accumulator with valid/ready output.
// Optional received-parity check enabled by defining PARITY_CHECK_EN.
`default_nettype none

module serial_parity_acc #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_x_bit,
  input  logic i_x_valid,
  output logic o_x_ready,
  output logic o_p,
  output logic o_p_valid,
  input  logic i_p_ready,
  output logic o_err,
  output logic o_busy
);

`ifdef PARITY_CHECK_EN
  localparam int LAST = FRAME_LEN + 1;
`else
  localparam int LAST = FRAME_LEN;
`endif
  localparam logic [CNT_W-1:0] c_CNT_FINAL = CNT_W'(LAST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_p;
  logic             r_p_valid;
  logic             r_x_ready;
  logic             r_busy;
`ifdef PARITY_CHECK_EN
  logic             r_err;
`endif

  logic w_accept;
  logic w_take;
  logic w_final;

  assign w_accept = i_x_valid & r_x_ready;
  assign w_take   = r_p_valid & i_p_ready;
  assign w_final  = (r_cnt == c_CNT_FINAL);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= 1'b0;
      r_p       <= 1'b0;
      r_p_valid <= 1'b0;
      r_x_ready <= 1'b1;
      r_busy    <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= i_x_bit;
            r_cnt   <= CNT_W'(1);
            r_state <= S_ACCUM;
            r_busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (w_final) begin
              r_state   <= S_HOLD;
              r_cnt     <= '0;
              r_p_valid <= 1'b1;
              r_x_ready <= 1'b0;
`ifdef PARITY_CHECK_EN
              // Last accepted bit is the received parity trailer, not data.
              r_p       <= r_acc;
              r_err     <= r_acc ^ i_x_bit;
`else
              r_p       <= r_acc ^ i_x_bit;
`endif
            end else begin
              r_acc <= r_acc ^ i_x_bit;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_take) begin
            r_p_valid <= 1'b0;
            r_state   <= S_IDLE;
            r_x_ready <= 1'b1;
            r_busy    <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_err     <= 1'b0;
`endif
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_p_valid <= 1'b0;
          r_x_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_x_ready = r_x_ready;
  assign o_p       = r_p;
  assign o_p_valid = r_p_valid;
  assign o_busy    = r_busy;
`ifdef PARITY_CHECK_EN
  assign o_err     = r_err;
`else
  assign o_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_acc.sv
// tb_serial_parity_acc: directed scoreboard bench for serial_parity_acc (8-bit and 2-bit frames).
`default_nettype none

module tb_serial_parity_acc;

  logic clk = 1'b0;
  logic rst_n;
  logic x_bit, x_valid, x_ready, p, p_valid, p_ready, err, busy;
  logic x2_bit, x2_valid, x2_ready, p2, p2_valid, p2_ready, err2, busy2;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int exp_pulses = 0;
  logic prev_pv = 1'b0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  serial_parity_acc #(.FRAME_LEN(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_x_bit(x_bit), .i_x_valid(x_valid),
    .o_x_ready(x_ready), .o_p(p), .o_p_valid(p_valid), .i_p_ready(p_ready),
    .o_err(err), .o_busy(busy)
  );

  serial_parity_acc #(.FRAME_LEN(2), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_x_bit(x2_bit), .i_x_valid(x2_valid),
    .o_x_ready(x2_ready), .o_p(p2), .o_p_valid(p2_valid), .i_p_ready(p2_ready),
    .o_err(err2), .o_busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score a take on the upcoming edge, then settle to the next falling edge.
  task automatic step();
    logic [1:0] e;
    if (p_valid && p_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("p", {31'd0, p}, {31'd0, e[1]});
        chk("err", {31'd0, err}, {31'd0, e[0]});
      end
    end
    prev_pv = p_valid;
    @(posedge clk);
    @(negedge clk);
    if (p_valid && !prev_pv) pulses++;
`ifndef PARITY_CHECK_EN
    chk("err_zero", {31'd0, err}, 32'd0);
`endif
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int budget;
    x_valid = 1'b1;
    x_bit   = b;
    budget  = 0;
    acc     = 1'b0;
    while (!acc && budget < 50) begin
      acc = x_ready;
      step();
      budget++;
    end
    if (!acc) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic trailer, input logic [7:0] gaps);
    logic e_p, e_err;
    e_p   = ^data;
    e_err = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(data[i]);
      if (gaps[i]) begin
        x_valid = 1'b0;
        step();
      end
    end
`ifdef PARITY_CHECK_EN
    send_bit(trailer);
    e_err = trailer ^ e_p;
`else
    e_err = 1'b0 & trailer;
`endif
    sb.push_back({e_p, e_err});
    exp_pulses++;
    x_valid = 1'b0;
    chk("pv_after_last", {31'd0, p_valid}, 32'd1);
    chk("xr_after_last", {31'd0, x_ready}, 32'd0);
  endtask

  task automatic send2(input logic b);
    logic acc;
    int budget;
    x2_valid = 1'b1;
    x2_bit   = b;
    budget   = 0;
    acc      = 1'b0;
    while (!acc && budget < 20) begin
      acc = x2_ready;
      step();
      budget++;
    end
    if (!acc) chk("accept2_timeout", 32'd1, 32'd0);
    x2_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; x_bit = 1'b0; x_valid = 1'b0; p_ready = 1'b1;
    x2_bit = 1'b0; x2_valid = 1'b0; p2_ready = 1'b1;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    chk("rst_pv", {31'd0, p_valid}, 32'd0);
    chk("rst_xr", {31'd0, x_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_p", {31'd0, p}, 32'd0);

    // Abandon a partial frame with a two-cycle reset.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    x_valid = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst2_pv", {31'd0, p_valid}, 32'd0);
    chk("rst2_xr", {31'd0, x_ready}, 32'd1);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    send_frame(8'b1011_0000, 1'b1, 8'h00);

    // Back-to-back frames.
    send_frame(8'b0000_0000, 1'b0, 8'h00);
    send_frame(8'b1111_1111, 1'b0, 8'h00);
    send_frame(8'b1000_0000, 1'b1, 8'h00);
    send_frame(8'b1100_0001, 1'b1, 8'h00);
    step();
    chk("b2b_pv_low", {31'd0, p_valid}, 32'd0);
    chk("b2b_pulses", pulses, exp_pulses);

    // Source gaps after bits 2 and 5.
    send_frame(8'b1010_1011, 1'b1, 8'b0010_0100);
    step();
    chk("gap_pulses", pulses, exp_pulses);

    // Backpressure with the next frame's first bit already presented.
    p_ready = 1'b0;
    send_frame(8'b1110_0000, 1'b1, 8'h00);
    x_valid = 1'b1;
    x_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_pv", {31'd0, p_valid}, 32'd1);
      chk("bp_p", {31'd0, p}, 32'd1);
      chk("bp_xr", {31'd0, x_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    p_ready = 1'b1;
    send_frame(8'b1000_0001, 1'b0, 8'h00);
    step();
    chk("bp_pulses", pulses, exp_pulses);

    // Received-parity trailer: good then bad.
    send_frame(8'b1101_0010, 1'b0, 8'h00);
    send_frame(8'b1101_0010, 1'b1, 8'h00);
    step();
    chk("chk_pulses", pulses, exp_pulses);

    // Two-bit frames on the small instance.
    send2(1'b0); send2(1'b1);
`ifdef PARITY_CHECK_EN
    send2(1'b1);
`endif
    chk("f2_pv", {31'd0, p2_valid}, 32'd1);
    chk("f2_p", {31'd0, p2}, 32'd1);
    chk("f2_err", {31'd0, err2}, 32'd0);
    chk("f2_busy", {31'd0, busy2}, 32'd1);
    step();
    chk("f2_pv_take", {31'd0, p2_valid}, 32'd0);
    chk("f2_busy_take", {31'd0, busy2}, 32'd0);
    send2(1'b1); send2(1'b1);
`ifdef PARITY_CHECK_EN
    send2(1'b0);
`endif
    chk("f2b_pv", {31'd0, p2_valid}, 32'd1);
    chk("f2b_p", {31'd0, p2}, 32'd0);
    step();
    chk("f2b_busy_take", {31'd0, busy2}, 32'd0);
    chk("f2b_p_kept", {31'd0, p2}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    chk("total_pulses", pulses, exp_pulses);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
